bus_memory_responder: RTL and testbench

Single-clock on-chip memory that acts as the responder (slave) end of the shared burst bus used by the camera grabber and other bus masters. It accepts single and burst write transactions, writing words under byte-enable control, and serves burst reads from the same storage. It sits on the system bus as a scratch/frame buffer and as the bench target for master-side blocks.

---
 rtl/bus_memory_responder.sv | 169 ++++++++++++++++
 tb/tb_bus_memory_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: on-chip word memory acting as the responder end of the
// shared burst bus. Handles single/burst writes with byte enables and burst reads.
// Optional build macro BUS_MEMORY_RESPONDER_WAIT_STATE_EN inserts a stall after
// every 4th write beat (busyOut) and an idle cycle after every 4th read beat.
`timescale 1ns/1ps
module bus_memory_responder #(
    parameter logic [31:0] baseAddress   = 32'h4000_0000,
    parameter int          nrOfWordsLog2 = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busyOut,
    output logic        busErrorOut
);

`ifdef BUS_MEMORY_RESPONDER_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int AW    = nrOfWordsLog2;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, WRITE, RD_FETCH, READ, RD_END} state_t;

    logic [31:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [8:0]    cnt_q, cnt_d;       // beats left minus one; MSB set = exhausted
    logic [3:0]    be_q, be_d;
    logic [1:0]    beat_q, beat_d;     // beat count mod 4 for wait-state insertion
    logic          gap_q, gap_d;       // next READ cycle is an inserted idle cycle
    logic [31:0]   data_q, data_d;
    logic          dv_q, dv_d;
    logic          eot_q, eot_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    // Address decode: window match plus burst must stay inside the window
    logic [AW-1:0] start_idx;
    logic [31:0]   last_idx;
    logic          addr_hit, hit, begin_hit, wr_accept, rd_issue, rd_done;
    logic          unused_addr_lsb;

    assign start_idx       = addressDataIn[AW+1:2];
    assign last_idx        = 32'(start_idx) + 32'(burstSizeIn);
    assign addr_hit        = addressDataIn[31:AW+2] == baseAddress[31:AW+2];
    assign hit             = addr_hit && (last_idx <= 32'(DEPTH - 1));
    assign begin_hit       = beginTransactionIn && hit && (state_q == IDLE);
    assign unused_addr_lsb = ^addressDataIn[1:0];

    assign wr_accept = (state_q == WRITE) && dataValidIn && !busy_q && !cnt_q[8];
    assign rd_issue  = (state_q == RD_FETCH) ||
                       ((state_q == READ) && !gap_q && !cnt_q[8]);
    assign rd_done   = (state_q == READ) && !gap_q && cnt_q[8];

    // State register and all control/output flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            beat_q  <= '0;
            gap_q   <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            eot_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            eot_q   <= eot_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (begin_hit) state_d = readNotWriteIn ? RD_FETCH : WRITE;
            WRITE:    if (endTransactionIn) state_d = IDLE;
            RD_FETCH: state_d = READ;
            READ:     if (rd_done) state_d = RD_END;
            RD_END:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs: pointer/counter stepping, read data, pulses
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        be_d   = be_q;
        beat_d = beat_q;
        gap_d  = gap_q;
        data_d = '0;
        dv_d   = 1'b0;
        eot_d  = 1'b0;
        busy_d = 1'b0;
        // A begin is an error if it misses the window or arrives mid-transaction
        err_d  = beginTransactionIn && ((state_q != IDLE) || !hit);

        if (begin_hit) begin
            ptr_d  = start_idx;
            cnt_d  = {1'b0, burstSizeIn};
            be_d   = byteEnablesIn;
            beat_d = '0;
            gap_d  = 1'b0;
        end

        if (wr_accept) begin
            ptr_d  = ptr_q + PTR_ONE;
            cnt_d  = cnt_q - 9'd1;
            beat_d = beat_q + 2'd1;
            busy_d = WAIT_EN && (beat_q == 2'd3);
        end

        if (rd_issue) begin
            data_d = mem[ptr_q];
            dv_d   = 1'b1;
            ptr_d  = ptr_q + PTR_ONE;
            cnt_d  = cnt_q - 9'd1;
            beat_d = beat_q + 2'd1;
            gap_d  = WAIT_EN && (beat_q == 2'd3);
        end

        if ((state_q == READ) && gap_q) gap_d = 1'b0;
        if (rd_done) eot_d = 1'b1;
    end

    // Memory write port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[ptr_q][8*b +: 8] <= addressDataIn[8*b +: 8];
            end
        end
    end

    assign addressDataOut    = data_q;
    assign dataValidOut      = dv_q;
    assign endTransactionOut = eot_q;
    assign busyOut           = busy_q;
    assign busErrorOut       = err_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed testbench for bus_memory_responder (default and wait-state builds).
`timescale 1ns/1ps
module tb_bus_memory_responder;
    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef BUS_MEMORY_RESPONDER_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        beginTransactionIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic [3:0]  byteEnablesIn = '0;
    logic [7:0]  burstSizeIn = '0;
    logic        readNotWriteIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic [31:0] addressDataOut;
    logic        dataValidOut, endTransactionOut, busyOut, busErrorOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] wdata [16];
    logic [31:0] rd_buf [16];
    int          rd_n, rd_eot;
    logic [63:0] rd_dvmask, rd_errmask;
    logic        rd_badz;
    logic [31:0] wr_errmask, wr_busymask;

    bus_memory_responder dut (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
        .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .addressDataOut(addressDataOut),
        .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
        .busyOut(busyOut), .busErrorOut(busErrorOut)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected endTransactionOut cycle for an n-beat read (begin = cycle 0)
    function automatic int eot_exp(input int n);
        return 2 + n + (WAIT_EN ? n / 4 : 0);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                            input logic [7:0] burst, input int nsend);
        int c;
        int g;
        c = 0;
        wr_errmask = '0;
        wr_busymask = '0;
        beginTransactionIn = 1'b1; addressDataIn = addr; byteEnablesIn = be;
        burstSizeIn = burst; readNotWriteIn = 1'b0;
        tick(); c++;
        if (busErrorOut) wr_errmask[c] = 1'b1;
        beginTransactionIn = 1'b0; byteEnablesIn = '0; burstSizeIn = '0;
        for (int i = 0; i < nsend; i++) begin
            g = 0;
            while (busyOut && g < 8) begin
                wr_busymask[i] = 1'b1;
                dataValidIn = 1'b0;
                tick(); c++;
                if (busErrorOut) wr_errmask[c] = 1'b1;
                g++;
            end
            dataValidIn = 1'b1; addressDataIn = wdata[i];
            tick(); c++;
            if (busErrorOut) wr_errmask[c] = 1'b1;
        end
        dataValidIn = 1'b0; addressDataIn = '0;
        if (busyOut) wr_busymask[nsend] = 1'b1;
        endTransactionIn = 1'b1;
        tick(); c++;
        if (busErrorOut) wr_errmask[c] = 1'b1;
        endTransactionIn = 1'b0;
    endtask

    // dup > 0 pulses an extra (illegal) begin in that cycle of the burst
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] burst, input int dup);
        rd_n = 0; rd_eot = -1; rd_dvmask = '0; rd_errmask = '0; rd_badz = 1'b0;
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; addressDataIn = addr;
        burstSizeIn = burst;
        tick();
        beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; addressDataIn = '0; burstSizeIn = '0;
        for (int c = 1; c <= 60; c++) begin
            if (busErrorOut) rd_errmask[c] = 1'b1;
            if (dataValidOut) begin
                rd_dvmask[c] = 1'b1;
                if (rd_n < 16) rd_buf[rd_n] = addressDataOut;
                rd_n++;
            end else if (addressDataOut !== 32'h0) begin
                rd_badz = 1'b1;
            end
            if (endTransactionOut) begin
                rd_eot = c;
                break;
            end
            if (c == dup) begin
                beginTransactionIn = 1'b1; addressDataIn = BASE; burstSizeIn = '0;
            end else begin
                beginTransactionIn = 1'b0; addressDataIn = '0;
            end
            tick();
        end
        beginTransactionIn = 1'b0; addressDataIn = '0;
        tick();
        chk("eot_one_cycle", endTransactionOut, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut}, 0);
        reset = 1'b1;
        tick();

        // Burst write of 4 words at word 4, then read back
        wdata[0] = 32'd1; wdata[1] = 32'd2; wdata[2] = 32'd3; wdata[3] = 32'd4;
        do_write(BASE + 32'h10, 4'hF, 8'd3, 4);
        chk("wr4_no_error", wr_errmask, 0);
        read_burst(BASE + 32'h10, 8'd3, 0);
        chk("rd4_beats", rd_n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rd4_word%0d", i), rd_buf[i], i + 1);
        chk("rd4_valid_cycles", rd_dvmask, 64'h3C);
        chk("rd4_eot_cycle", rd_eot, eot_exp(4));
        chk("rd4_zero_when_idle", rd_badz, 0);
        chk("rd4_no_error", rd_errmask, 0);

        // Byte-enable merge into word 0
        wdata[0] = 32'hAABBCCDD;
        do_write(BASE, 4'hF, 8'd0, 1);
        wdata[0] = 32'h11223344;
        do_write(BASE, 4'b0101, 8'd0, 1);
        read_burst(BASE, 8'd0, 0);
        chk("be_merge", rd_buf[0], 32'hAA22CC44);
        chk("be_single_beat", rd_n, 1);
        chk("single_eot_cycle", rd_eot, 3);

        // Miss just past the window: error at cycle 1 only, word 0 untouched
        wdata[0] = 32'hDEADBEEF;
        do_write(BASE + 32'h800, 4'hF, 8'd0, 1);
        chk("miss_err_pulse", wr_errmask, 32'h2);
        read_burst(BASE, 8'd0, 0);
        chk("miss_mem_kept", rd_buf[0], 32'hAA22CC44);

        // Last word: single beat is legal, burst of 2 crosses the end
        wdata[0] = 32'h5115_5115;
        do_write(BASE + 32'h7FC, 4'hF, 8'd0, 1);
        chk("last_word_hit", wr_errmask, 0);
        wdata[0] = 32'hBAD0_0001; wdata[1] = 32'hBAD0_0002;
        do_write(BASE + 32'h7FC, 4'hF, 8'd1, 2);
        chk("cross_end_err_pulse", wr_errmask, 32'h2);
        read_burst(BASE + 32'h7FC, 8'd0, 0);
        chk("cross_end_mem_kept", rd_buf[0], 32'h5115_5115);

        // Early end after 2 of 8 beats
        wdata[0] = 32'hA0; wdata[1] = 32'hA1; wdata[2] = 32'hA2;
        do_write(BASE, 4'hF, 8'd2, 3);
        wdata[0] = 32'hB0; wdata[1] = 32'hB1;
        do_write(BASE, 4'hF, 8'd7, 2);
        read_burst(BASE, 8'd2, 0);
        chk("early_word0", rd_buf[0], 32'hB0);
        chk("early_word1", rd_buf[1], 32'hB1);
        chk("early_word2_kept", rd_buf[2], 32'hA2);
        chk("early_fsm_idle", rd_errmask, 0);

        // Begin during a read burst: error next cycle, burst unaffected
        read_burst(BASE + 32'h10, 8'd3, 1);
        chk("busy_begin_err", rd_errmask, 64'h4);
        chk("busy_begin_beats", rd_n, 4);
        chk("busy_begin_word3", rd_buf[3], 32'd4);
        chk("busy_begin_eot", rd_eot, eot_exp(4));

        // 8-beat write and read: wait states when enabled
        for (int i = 0; i < 8; i++) wdata[i] = 32'h100 + i;
        do_write(BASE + 32'h40, 4'hF, 8'd7, 8);
        chk("wr8_busy_pattern", wr_busymask, WAIT_EN ? 32'h110 : 32'h0);
        read_burst(BASE + 32'h40, 8'd7, 0);
        chk("rd8_beats", rd_n, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("rd8_word%0d", i), rd_buf[i], 32'h100 + i);
        chk("rd8_valid_cycles", rd_dvmask, WAIT_EN ? 64'h7BC : 64'h3FC);
        chk("rd8_eot_cycle", rd_eot, eot_exp(8));

        // Asynchronous reset in the middle of a read burst
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; addressDataIn = BASE + 32'h10;
        burstSizeIn = 8'd3;
        tick();
        beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; addressDataIn = '0; burstSizeIn = '0;
        tick();
        tick();
        chk("pre_reset_valid", dataValidOut, 1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs",
               {addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut}, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        tick();
        chk("post_reset_outputs",
            {addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut}, 0);
        read_burst(BASE, 8'd0, 0);
        chk("post_reset_word0", rd_buf[0], 32'hB0);
        chk("post_reset_eot", rd_eot, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
